pipe_ctrl_unit: RTL and testbench

- Registered, stall-aware control unit for the 5-stage pipelined processor. Generalises the single-cycle decoder to the full ISA.
- Decodes the ID-stage instruction fields into control signals and registers them into the ID/EX control latch.
- Detects load-use hazards and holds ID for a parameterised multiply/divide latency.
- Honours a branch/jump flush from EX.

---
 rtl/pipe_ctrl_unit.sv | 166 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: registered, stall-aware control unit for the 5-stage pipeline.
// Decodes the ID-stage instruction into control signals and latches them into the
// ID/EX control register. It holds ID on a load-use hazard and while a mul/div
// occupies EX, and it turns the latch into a bubble when EX resolves a taken
// branch or jump.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   id_valid                ID holds a real instruction
//   id_opcode, id_aluop     opcode [31:27] and ALU-op [6:2] fields
//   id_rd, id_rs, id_rt     register specifier fields
//   ex_flush                taken branch/jump resolved in EX
//   id_ready                ID may advance this cycle
//   id_src2                 second read register (id_rd for Rdst forms, else id_rt)
//   ex_*                    ID/EX control latch contents
module pipe_ctrl_unit #(
  parameter int unsigned OPW      = 5,
  parameter int unsigned REGW     = 5,
  parameter int unsigned MD_LAT   = 8,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_opcode,
  input  logic [OPW-1:0]  id_aluop,
  input  logic [REGW-1:0] id_rd,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            ex_flush,
  output logic            id_ready,
  output logic [REGW-1:0] id_src2,
  output logic            ex_valid,
  output logic            ex_Rwe,
  output logic            ex_ALUinB,
  output logic [OPW-1:0]  ex_aluop,
  output logic            ex_DMwe,
  output logic            ex_Rwd,
  output logic [1:0]      ex_br,
  output logic [1:0]      ex_jmp,
  output logic            ex_setx,
  output logic            ex_md,
  output logic [REGW-1:0] ex_rd
);

  localparam int unsigned CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  localparam logic [OPW-1:0] OpR    = OPW'(0);
  localparam logic [OPW-1:0] OpJ    = OPW'(1);
  localparam logic [OPW-1:0] OpBne  = OPW'(2);
  localparam logic [OPW-1:0] OpJal  = OPW'(3);
  localparam logic [OPW-1:0] OpJr   = OPW'(4);
  localparam logic [OPW-1:0] OpAddi = OPW'(5);
  localparam logic [OPW-1:0] OpBlt  = OPW'(6);
  localparam logic [OPW-1:0] OpSw   = OPW'(7);
  localparam logic [OPW-1:0] OpLw   = OPW'(8);
  localparam logic [OPW-1:0] OpSetx = OPW'(21);
  localparam logic [OPW-1:0] OpBex  = OPW'(22);

  localparam logic [OPW-1:0] AluMul = OPW'(6);
  localparam logic [OPW-1:0] AluDiv = OPW'(7);
  localparam logic [OPW-1:0] AluSub = OPW'(1);

  logic is_r, is_j, is_bne, is_jal, is_jr, is_addi, is_blt, is_sw, is_lw, is_setx, is_bex;
  logic legal, rdst, uses_rs, uses_src2, hazard, load;
  logic dec_rwe, dec_aluinb, dec_md;
  logic [OPW-1:0]  dec_aluop;
  logic [1:0]      dec_br, dec_jmp;
  logic [REGW-1:0] dec_rd;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign is_r    = (id_opcode == OpR);
  assign is_j    = (id_opcode == OpJ);
  assign is_bne  = (id_opcode == OpBne);
  assign is_jal  = (id_opcode == OpJal);
  assign is_jr   = (id_opcode == OpJr);
  assign is_addi = (id_opcode == OpAddi);
  assign is_blt  = (id_opcode == OpBlt);
  assign is_sw   = (id_opcode == OpSw);
  assign is_lw   = (id_opcode == OpLw);
  assign is_setx = (id_opcode == OpSetx);
  assign is_bex  = (id_opcode == OpBex);

  assign legal = is_r | is_j | is_bne | is_jal | is_jr | is_addi | is_blt | is_sw | is_lw |
                 is_setx | is_bex;

  always_comb begin
    dec_rwe    = is_r | is_addi | is_lw | is_jal | is_setx;
    dec_aluinb = is_addi | is_lw | is_sw;
    dec_md     = is_r & ((id_aluop == AluMul) | (id_aluop == AluDiv));
    dec_aluop  = '0;
    if (is_r) begin
      dec_aluop = id_aluop;
    end else if (is_bne | is_blt) begin
      dec_aluop = AluSub;
    end
    dec_br  = {is_blt | is_bex, is_bne | is_bex};
    dec_jmp = {is_jal | is_jr, is_j | is_jr};
    dec_rd  = id_rd;
    if (is_jal) begin
      dec_rd = REGW'(31);
    end else if (is_setx) begin
      dec_rd = REGW'(30);
    end
  end

  assign rdst      = is_sw | is_bne | is_blt | is_jr;
  assign id_src2   = rdst ? id_rd : id_rt;
  assign uses_rs   = is_r | is_addi | is_lw | is_sw | is_bne | is_blt;
  assign uses_src2 = is_r | is_sw | is_bne | is_blt | is_jr;

  // Only a load in EX can hazard; its result is not forwardable until MEM.
  assign hazard = ex_valid & ex_Rwd & (ex_rd != REGW'(ZERO_REG)) &
                  (((ex_rd == id_rs) & uses_rs) | ((ex_rd == id_src2) & uses_src2));

  assign id_ready = ~(id_valid & hazard) & (cnt_q == '0);

  // An invalid or illegal ID slot latches as a full bubble, not just ex_valid=0.
  always_comb begin
    cnt_d = cnt_q;
    load  = 1'b0;
    if (ex_flush) begin
      cnt_d = '0;
    end else if (!id_ready) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (id_valid & legal) begin
      load = 1'b1;
      if (dec_md) begin
        cnt_d = CW'(MD_LAT - 1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      ex_valid  <= 1'b0;
      ex_Rwe    <= 1'b0;
      ex_ALUinB <= 1'b0;
      ex_aluop  <= '0;
      ex_DMwe   <= 1'b0;
      ex_Rwd    <= 1'b0;
      ex_br     <= '0;
      ex_jmp    <= '0;
      ex_setx   <= 1'b0;
      ex_md     <= 1'b0;
      ex_rd     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ex_valid  <= load;
      ex_Rwe    <= load & dec_rwe;
      ex_ALUinB <= load & dec_aluinb;
      ex_aluop  <= load ? dec_aluop : '0;
      ex_DMwe   <= load & is_sw;
      ex_Rwd    <= load & is_lw;
      ex_br     <= load ? dec_br : '0;
      ex_jmp    <= load ? dec_jmp : '0;
      ex_setx   <= load & is_setx;
      ex_md     <= load & dec_md;
      ex_rd     <= load ? dec_rd : '0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios with literal
// expectations, then randomized instruction streams checked every cycle against
// a behavioural model of the ID/EX control latch.
module tb_pipe_ctrl_unit;

  localparam int MD_LAT = 8;

  logic       clock, reset, id_valid, ex_flush;
  logic [4:0] id_opcode, id_aluop, id_rd, id_rs, id_rt;
  logic       id_ready, ex_valid, ex_Rwe, ex_ALUinB, ex_DMwe, ex_Rwd, ex_setx, ex_md;
  logic [4:0] id_src2, ex_aluop, ex_rd;
  logic [1:0] ex_br, ex_jmp;

  int tests = 0;
  int fails = 0;

  pipe_ctrl_unit #(
    .OPW      (5),
    .REGW     (5),
    .MD_LAT   (MD_LAT),
    .ZERO_REG (0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_aluop  (id_aluop),
    .id_rd     (id_rd),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .ex_flush  (ex_flush),
    .id_ready  (id_ready),
    .id_src2   (id_src2),
    .ex_valid  (ex_valid),
    .ex_Rwe    (ex_Rwe),
    .ex_ALUinB (ex_ALUinB),
    .ex_aluop  (ex_aluop),
    .ex_DMwe   (ex_DMwe),
    .ex_Rwd    (ex_Rwd),
    .ex_br     (ex_br),
    .ex_jmp    (ex_jmp),
    .ex_setx   (ex_setx),
    .ex_md     (ex_md),
    .ex_rd     (ex_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       valid, rwe, aluinb;
    logic [4:0] aluop;
    logic       dmwe, rwd;
    logic [1:0] br, jmp;
    logic       setx, md;
    logic [4:0] rd;
  } ex_t;

  function automatic ex_t decode(input logic [4:0] op, input logic [4:0] alu,
                                 input logic [4:0] rd);
    ex_t e;
    e       = '0;
    e.valid = 1'b1;
    e.rd    = rd;
    case (op)
      5'd0:  begin e.rwe = 1'b1; e.aluop = alu; e.md = (alu == 5'd6) || (alu == 5'd7); end
      5'd1:  e.jmp = 2'b01;
      5'd2:  begin e.br = 2'b01; e.aluop = 5'd1; end
      5'd3:  begin e.jmp = 2'b10; e.rwe = 1'b1; e.rd = 5'd31; end
      5'd4:  e.jmp = 2'b11;
      5'd5:  begin e.rwe = 1'b1; e.aluinb = 1'b1; end
      5'd6:  begin e.br = 2'b10; e.aluop = 5'd1; end
      5'd7:  begin e.dmwe = 1'b1; e.aluinb = 1'b1; end
      5'd8:  begin e.rwe = 1'b1; e.aluinb = 1'b1; e.rwd = 1'b1; end
      5'd21: begin e.rwe = 1'b1; e.setx = 1'b1; e.rd = 5'd30; end
      5'd22: e.br = 2'b11;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic reads_rs(input logic [4:0] op);
    return op inside {5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6};
  endfunction

  function automatic logic reads_src2(input logic [4:0] op);
    return op inside {5'd0, 5'd7, 5'd2, 5'd6, 5'd4};
  endfunction

  function automatic logic src2_is_rd(input logic [4:0] op);
    return op inside {5'd7, 5'd2, 5'd6, 5'd4};
  endfunction

  ex_t        m_ex = '0;
  ex_t        m_dec;
  int         cyc = 0;
  int         md_until = 0;   // first cycle index at which a mul/div no longer blocks ID
  logic [4:0] m_src2;
  logic       m_haz, m_ready;

  always_comb begin
    m_dec   = decode(id_opcode, id_aluop, id_rd);
    m_src2  = src2_is_rd(id_opcode) ? id_rd : id_rt;
    m_haz   = m_ex.valid && m_ex.rwd && (m_ex.rd != 5'd0) &&
              ((reads_rs(id_opcode) && (id_rs == m_ex.rd)) ||
               (reads_src2(id_opcode) && (m_src2 == m_ex.rd)));
    m_ready = !(id_valid && m_haz) && (cyc >= md_until);
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ex     <= '0;
      cyc      <= 0;
      md_until <= 0;
    end else begin
      cyc <= cyc + 1;
      if (ex_flush) begin
        m_ex     <= '0;
        md_until <= 0;
      end else if (!m_ready) begin
        m_ex <= '0;
      end else if (id_valid && m_dec.valid) begin
        m_ex <= m_dec;
        if (m_dec.md) md_until <= cyc + MD_LAT;
      end else begin
        m_ex <= '0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    check("id_ready",  32'(id_ready),  32'(m_ready));
    check("id_src2",   32'(id_src2),   32'(m_src2));
    check("ex_valid",  32'(ex_valid),  32'(m_ex.valid));
    check("ex_Rwe",    32'(ex_Rwe),    32'(m_ex.rwe));
    check("ex_ALUinB", 32'(ex_ALUinB), 32'(m_ex.aluinb));
    check("ex_aluop",  32'(ex_aluop),  32'(m_ex.aluop));
    check("ex_DMwe",   32'(ex_DMwe),   32'(m_ex.dmwe));
    check("ex_Rwd",    32'(ex_Rwd),    32'(m_ex.rwd));
    check("ex_br",     32'(ex_br),     32'(m_ex.br));
    check("ex_jmp",    32'(ex_jmp),    32'(m_ex.jmp));
    check("ex_setx",   32'(ex_setx),   32'(m_ex.setx));
    check("ex_md",     32'(ex_md),     32'(m_ex.md));
    check("ex_rd",     32'(ex_rd),     32'(m_ex.rd));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] alu,
                       input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    id_valid  = v;
    id_opcode = op;
    id_aluop  = alu;
    id_rd     = rd;
    id_rs     = rs;
    id_rt     = rt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  logic [4:0] ops [12];
  int         n;

  initial begin
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd31};
    ex_flush = 1'b0;
    reset    = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd3, 5'd1, 5'd2);   // add r3,r1,r2
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    at_neg();
    check("rst ex_valid", 32'(ex_valid), 32'd0);
    check("rst ex_Rwe",   32'(ex_Rwe),   32'd0);
    check("rst id_ready", 32'(id_ready), 32'd1);
    step();
    reset = 1'b1;
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    at_neg();
    check("add ex_valid", 32'(ex_valid), 32'd1);
    check("add ex_Rwe",   32'(ex_Rwe),   32'd1);
    check("add ex_aluop", 32'(ex_aluop), 32'd0);
    check("add ex_rd",    32'(ex_rd),    32'd3);

    // lw r5 then add r6,r5,r1: one stall, one bubble.
    drive(1'b1, 5'd8, 5'd0, 5'd5, 5'd1, 5'd0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 5'd5, 5'd1);
    at_neg();
    check("lu stall ready", 32'(id_ready), 32'd0);
    step();
    at_neg();
    check("lu bubble valid", 32'(ex_valid), 32'd0);
    check("lu resume ready", 32'(id_ready), 32'd1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    at_neg();
    check("lu add valid", 32'(ex_valid), 32'd1);
    check("lu add rd",    32'(ex_rd),    32'd6);

    // lw r0 then add r6,r0,r1: no stall.
    drive(1'b1, 5'd8, 5'd0, 5'd0, 5'd1, 5'd0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 5'd0, 5'd1);
    at_neg();
    check("lw r0 ready", 32'(id_ready), 32'd1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    // mul r4,r1,r2 then add r7: seven stall cycles.
    drive(1'b1, 5'd0, 5'd6, 5'd4, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 5'd1, 5'd2);
    at_neg();
    check("mul ex_md", 32'(ex_md), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (id_ready) break;
      n++;
      step();
      at_neg();
    end
    check("mul stall cycles", 32'(n), 32'd7);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    at_neg();
    check("after mul valid", 32'(ex_valid), 32'd1);
    check("after mul rd",    32'(ex_rd),    32'd7);
    check("after mul md",    32'(ex_md),    32'd0);

    // bne r1,r2 then flush while the next instruction decodes.
    drive(1'b1, 5'd2, 5'd0, 5'd2, 5'd1, 5'd0);
    step();
    drive(1'b1, 5'd7, 5'd0, 5'd7, 5'd1, 5'd0);
    ex_flush = 1'b1;
    step();
    ex_flush = 1'b0;
    at_neg();
    check("flush ex_valid", 32'(ex_valid), 32'd0);
    check("sw id_src2",     32'(id_src2),  32'd7);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    at_neg();
    check("sw ex_DMwe",   32'(ex_DMwe),   32'd1);
    check("sw ex_ALUinB", 32'(ex_ALUinB), 32'd1);

    // jal, setx, illegal opcode.
    drive(1'b1, 5'd3, 5'd0, 5'd9, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd21, 5'd0, 5'd9, 5'd0, 5'd0);
    at_neg();
    check("jal ex_rd",   32'(ex_rd),   32'd31);
    check("jal ex_jmp",  32'(ex_jmp),  32'd2);
    check("jal ex_Rwe",  32'(ex_Rwe),  32'd1);
    check("model jal rd", 32'(m_ex.rd), 32'd31);
    step();
    drive(1'b1, 5'd31, 5'd0, 5'd9, 5'd1, 5'd2);
    at_neg();
    check("setx ex_rd",   32'(ex_rd),   32'd30);
    check("setx ex_setx", 32'(ex_setx), 32'd1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    at_neg();
    check("illegal ex_valid", 32'(ex_valid), 32'd0);
    check("illegal ex_Rwe",   32'(ex_Rwe),   32'd0);

    // Flush concurrent with a mul/div stall.
    drive(1'b1, 5'd0, 5'd7, 5'd4, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd8, 5'd1, 5'd2);
    ex_flush = 1'b1;
    at_neg();
    check("div stall ready", 32'(id_ready), 32'd0);
    step();
    ex_flush = 1'b0;
    at_neg();
    check("flush clears stall", 32'(id_ready), 32'd1);
    check("model flush ready",  32'(m_ready),  32'd1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    // Reset mid-stall.
    drive(1'b1, 5'd0, 5'd6, 5'd4, 5'd1, 5'd2);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 5'd1, 5'd2);
    at_neg();
    check("pre-rst ready", 32'(id_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid-rst ready", 32'(id_ready), 32'd1);
    check("mid-rst ex_md", 32'(ex_md),    32'd0);
    step();
    reset = 1'b1;

    // Randomized streams.
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] op, alu;
      int         k;
      k  = int'($urandom_range(0, 11));
      op = (k == 11) ? 5'($urandom_range(9, 20)) : ops[k];
      case ($urandom_range(0, 7))
        0:       alu = 5'd6;
        1:       alu = 5'd7;
        2, 3, 4: alu = 5'd0;
        default: alu = 5'($urandom_range(0, 31));
      endcase
      drive(($urandom_range(0, 99) < 85), op, alu, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      ex_flush = ($urandom_range(0, 99) < 8);
      step();
    end
    ex_flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    at_neg();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
